// File: rtl/reservation_station.sv
// Reservation station: compacted age-ordered queue that captures operands from the
// completion broadcast and issues the oldest fully-ready op over valid/ready.
module reservation_station #(
  parameter int DEPTH      = 4,
  parameter int ROBsize    = 8,
  parameter int ROBsizeLog = $clog2(ROBsize + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       write_en_i,
  input  logic [ROBsizeLog-1:0]      rob_tag_i,
  input  logic [ROBsizeLog-1:0]      tag1_i,
  input  logic [ROBsizeLog-1:0]      tag2_i,
  input  logic [64:0]                val1_i,
  input  logic [64:0]                val2_i,
  input  logic [9:0]                 commands_i,
  output logic                       stall_o,
  input  logic                       cdb_valid_i,
  input  logic [ROBsizeLog-1:0]      cdb_tag_i,
  input  logic [64:0]                cdb_val_i,
  output logic                       issue_valid_o,
  input  logic                       issue_ready_i,
  output logic [ROBsizeLog-1:0]      issue_rob_tag_o,
  output logic [64:0]                issue_val1_o,
  output logic [64:0]                issue_val2_o,
  output logic [9:0]                 issue_commands_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic                  valid;
    logic [ROBsizeLog-1:0] rob_tag;
    logic [ROBsizeLog-1:0] tag1;
    logic [64:0]           val1;
    logic [ROBsizeLog-1:0] tag2;
    logic [64:0]           val2;
    logic [9:0]            commands;
  } entry_t;

  entry_t        slot_q [DEPTH];
  entry_t        slot_d [DEPTH];
  entry_t        snp_s  [DEPTH+1];
  entry_t        new_s;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [CW-1:0] wr_idx_s;
  logic [DEPTH-1:0] ready_s;
  logic [IW-1:0] sel_s;
  logic          wr_acc_s;
  logic          issue_fire_s;

  // Snooped view of every slot; the extra top entry is an empty filler for the shift.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      snp_s[i] = slot_q[i];
      if (slot_q[i].valid && (slot_q[i].tag1 != '0) && cdb_valid_i && (cdb_tag_i == slot_q[i].tag1)) begin
        snp_s[i].tag1 = '0;
        snp_s[i].val1 = cdb_val_i;
      end else begin
        snp_s[i].tag1 = slot_q[i].tag1;
      end
      if (slot_q[i].valid && (slot_q[i].tag2 != '0) && cdb_valid_i && (cdb_tag_i == slot_q[i].tag2)) begin
        snp_s[i].tag2 = '0;
        snp_s[i].val2 = cdb_val_i;
      end else begin
        snp_s[i].tag2 = slot_q[i].tag2;
      end
    end
    snp_s[DEPTH] = '0;
  end

  // Incoming op, with operands captured from a broadcast arriving in the same cycle.
  always_comb begin
    new_s          = '0;
    new_s.valid    = 1'b1;
    new_s.rob_tag  = rob_tag_i;
    new_s.commands = commands_i;
    if ((tag1_i != '0) && cdb_valid_i && (cdb_tag_i == tag1_i)) begin
      new_s.tag1 = '0;
      new_s.val1 = cdb_val_i;
    end else begin
      new_s.tag1 = tag1_i;
      new_s.val1 = val1_i;
    end
    if ((tag2_i != '0) && cdb_valid_i && (cdb_tag_i == tag2_i)) begin
      new_s.tag2 = '0;
      new_s.val2 = cdb_val_i;
    end else begin
      new_s.tag2 = tag2_i;
      new_s.val2 = val2_i;
    end
  end

  // Readiness from registered state only, so a wakeup costs one cycle; pick the oldest.
  always_comb begin
    ready_s = '0;
    sel_s   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ready_s[i] = slot_q[i].valid && (slot_q[i].tag1 == '0) && (slot_q[i].tag2 == '0);
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready_s[i]) begin
        sel_s = IW'(i);
      end else begin
        sel_s = sel_s;
      end
    end
  end

  // Issue port, zeroed whenever nothing is presented.
  always_comb begin
    issue_valid_o    = |ready_s;
    issue_rob_tag_o  = '0;
    issue_val1_o     = 65'd0;
    issue_val2_o     = 65'd0;
    issue_commands_o = 10'd0;
    if (issue_valid_o) begin
      issue_rob_tag_o  = slot_q[sel_s].rob_tag;
      issue_val1_o     = slot_q[sel_s].val1;
      issue_val2_o     = slot_q[sel_s].val2;
      issue_commands_o = slot_q[sel_s].commands;
    end else begin
      issue_rob_tag_o  = '0;
    end
  end

  // Compaction shift past the issued slot, then append the new op behind the survivors.
  always_comb begin
    stall_o      = (count_q == CW'(DEPTH));
    wr_acc_s     = write_en_i & ~stall_o;
    issue_fire_s = issue_valid_o & issue_ready_i;
    wr_idx_s     = count_q - {{(CW-1){1'b0}}, issue_fire_s};
    count_d      = count_q + {{(CW-1){1'b0}}, wr_acc_s} - {{(CW-1){1'b0}}, issue_fire_s};
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_acc_s && (wr_idx_s == CW'(i))) begin
        slot_d[i] = new_s;
      end else if (issue_fire_s && (IW'(i) >= sel_s)) begin
        slot_d[i] = snp_s[i+1];
      end else begin
        slot_d[i] = snp_s[i];
      end
    end
  end

  assign count_o = count_q;

  // State registers.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench for reservation_station: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_reservation_station;

  localparam int DEPTH = 4;
  localparam int TW    = 4;
  localparam int CW    = 3;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          write_en_i;
  logic [TW-1:0] rob_tag_i, tag1_i, tag2_i;
  logic [64:0]   val1_i, val2_i;
  logic [9:0]    commands_i;
  logic          stall_o;
  logic          cdb_valid_i;
  logic [TW-1:0] cdb_tag_i;
  logic [64:0]   cdb_val_i;
  logic          issue_valid_o;
  logic          issue_ready_i;
  logic [TW-1:0] issue_rob_tag_o;
  logic [64:0]   issue_val1_o, issue_val2_o;
  logic [9:0]    issue_commands_o;
  logic [CW-1:0] count_o;

  reservation_station #(.DEPTH(DEPTH), .ROBsize(8)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .write_en_i(write_en_i), .rob_tag_i(rob_tag_i),
    .tag1_i(tag1_i), .tag2_i(tag2_i), .val1_i(val1_i), .val2_i(val2_i),
    .commands_i(commands_i), .stall_o(stall_o), .cdb_valid_i(cdb_valid_i),
    .cdb_tag_i(cdb_tag_i), .cdb_val_i(cdb_val_i), .issue_valid_o(issue_valid_o),
    .issue_ready_i(issue_ready_i), .issue_rob_tag_o(issue_rob_tag_o),
    .issue_val1_o(issue_val1_o), .issue_val2_o(issue_val2_o),
    .issue_commands_o(issue_commands_o), .count_o(count_o)
  );

  initial forever #5 clk_i = ~clk_i;

  typedef struct {
    logic [TW-1:0] rob, t1, t2;
    logic [64:0]   v1, v2;
    logic [9:0]    cmd;
  } ent_t;

  ent_t mq[$];
  int vectors = 0;
  int miscompares = 0;

  logic [148:0] obs_s;
  logic [148:0] exp_v;
  assign obs_s = {stall_o, count_o, issue_valid_o, issue_rob_tag_o, issue_val1_o,
                  issue_val2_o, issue_commands_o};

  function automatic int oldest_ready();
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].t1 == 0 && mq[i].t2 == 0) return i;
    return -1;
  endfunction

  function automatic logic [148:0] exp_bundle();
    int s = oldest_ready();
    logic st = (mq.size() == DEPTH);
    logic [CW-1:0] c = CW'(mq.size());
    if (s < 0) return {st, c, 1'b0, 144'd0};
    return {st, c, 1'b1, mq[s].rob, mq[s].v1, mq[s].v2, mq[s].cmd};
  endfunction

  function automatic logic [64:0] rnd65();
    logic [95:0] t = {$urandom, $urandom, $urandom};
    return t[64:0];
  endfunction

  task automatic drive(input logic we, input logic [TW-1:0] rob, t1, t2,
                       input logic [64:0] v1, v2, input logic cv,
                       input logic [TW-1:0] ct, input logic [64:0] cval, input logic rdy);
    write_en_i = we; rob_tag_i = rob; tag1_i = t1; tag2_i = t2;
    val1_i = v1; val2_i = v2; commands_i = 10'($urandom);
    cdb_valid_i = cv; cdb_tag_i = ct; cdb_val_i = cval; issue_ready_i = rdy;
  endtask

  // Advance one clock edge and apply the same edge to the model (called at a negedge).
  task automatic tick();
    int s = oldest_ready();
    bit full = (mq.size() == DEPTH);
    ent_t e;
    @(posedge clk_i);
    foreach (mq[i]) begin
      if (cdb_valid_i && cdb_tag_i != 0 && mq[i].t1 == cdb_tag_i) begin mq[i].t1 = 0; mq[i].v1 = cdb_val_i; end
      if (cdb_valid_i && cdb_tag_i != 0 && mq[i].t2 == cdb_tag_i) begin mq[i].t2 = 0; mq[i].v2 = cdb_val_i; end
    end
    if (s >= 0 && issue_ready_i) mq.delete(s);
    if (write_en_i && !full) begin
      e.rob = rob_tag_i; e.cmd = commands_i;
      e.t1 = tag1_i; e.v1 = val1_i; e.t2 = tag2_i; e.v2 = val2_i;
      if (cdb_valid_i && tag1_i != 0 && cdb_tag_i == tag1_i) begin e.t1 = 0; e.v1 = cdb_val_i; end
      if (cdb_valid_i && tag2_i != 0 && cdb_tag_i == tag2_i) begin e.t2 = 0; e.v2 = cdb_val_i; end
      mq.push_back(e);
    end
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b1;
    mq.delete();
    #1;
    vectors++;
    if (obs_s !== 149'd0) begin
      miscompares++;
      $display("FAIL reset_idle: got %h expected 0", obs_s);
    end
  endtask

  task automatic test_ready_dispatch();
    for (int c = 0; c < 3; c++) begin
      if (c == 0) drive(1, 4'd3, 0, 0, 65'd5, 65'd7, 0, 0, 0, 1);
      else        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      #1; exp_v = exp_bundle(); vectors++;
      if (obs_s !== exp_v) begin
        miscompares++; $display("FAIL ready_dispatch c%0d: got %h expected %h", c, obs_s, exp_v);
      end
      vectors++;
      if (c == 1 && {issue_valid_o, issue_rob_tag_o, issue_val1_o, issue_val2_o} !== {1'b1, 4'd3, 65'd5, 65'd7}) begin
        miscompares++; $display("FAIL ready_dispatch_issue: got v=%b tag=%0d v1=%0d v2=%0d expected 1/3/5/7",
                                issue_valid_o, issue_rob_tag_o, issue_val1_o, issue_val2_o);
      end else if (c == 2 && count_o !== 3'd0) begin
        miscompares++; $display("FAIL ready_dispatch_drain: got count %0d expected 0", count_o);
      end
      tick();
    end
  endtask

  task automatic test_wakeup(input bit on_write);
    int bc = on_write ? 0 : 2;
    for (int c = 0; c <= bc + 2; c++) begin
      drive(c == 0, 4'd2, c == 0 ? 4'd5 : 4'd0, 0, 65'd99, 65'd9,
            c == bc, 4'd5, 65'h1234, 1);
      #1; exp_v = exp_bundle(); vectors++;
      if (obs_s !== exp_v) begin
        miscompares++; $display("FAIL wakeup%0d c%0d: got %h expected %h", on_write, c, obs_s, exp_v);
      end
      vectors++;
      if (c == bc + 1 && {issue_valid_o, issue_val1_o} !== {1'b1, 65'h1234}) begin
        miscompares++; $display("FAIL wakeup%0d_issue: got v=%b val1=%h expected 1/1234", on_write, issue_valid_o, issue_val1_o);
      end else if (c <= bc && issue_valid_o !== 1'b0) begin
        miscompares++; $display("FAIL wakeup%0d_early: got issue_valid %b expected 0 at c%0d", on_write, issue_valid_o, c);
      end
      tick();
    end
  endtask

  task automatic test_age_order();
    for (int c = 0; c < 8; c++) begin
      case (c)
        0: drive(1, 4'd1, 4'd6, 0, 65'd11, 65'd12, 0, 0, 0, 0);
        1: drive(1, 4'd2, 0, 0, 65'd21, 65'd22, 0, 0, 0, 0);
        2: drive(1, 4'd3, 0, 0, 65'd31, 65'd32, 0, 0, 0, 0);
        3: drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        4: drive(0, 0, 0, 0, 0, 0, 1, 4'd6, 65'h66, 0);
        default: drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      endcase
      #1; exp_v = exp_bundle(); vectors++;
      if (obs_s !== exp_v) begin
        miscompares++; $display("FAIL age_order c%0d: got %h expected %h", c, obs_s, exp_v);
      end
      vectors++;
      if (c == 3 && issue_rob_tag_o !== 4'd2) begin
        miscompares++; $display("FAIL age_order_b_first: got tag %0d expected 2", issue_rob_tag_o);
      end else if (c == 5 && {issue_rob_tag_o, issue_val1_o} !== {4'd1, 65'h66}) begin
        miscompares++; $display("FAIL age_order_a_before_c: got tag %0d val1 %h expected 1/66", issue_rob_tag_o, issue_val1_o);
      end
      tick();
    end
  endtask

  task automatic test_full();
    for (int c = 0; c < 14; c++) begin
      if (c < 4)       drive(1, TW'(c + 1), TW'(c + 5), 0, 65'(c), 65'(c + 40), 0, 0, 0, 0);
      else if (c == 4) drive(1, 4'd8, 0, 0, 65'd77, 65'd78, 1, 4'd5, 65'hAAA, 0);
      else if (c < 7)  drive(1, 4'd8, 0, 0, 65'd77, 65'd78, 0, 0, 0, 1);
      else if (c < 10) drive(0, 0, 0, 0, 0, 0, 1, TW'(c - 1), rnd65(), 1);
      else             drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      #1; exp_v = exp_bundle(); vectors++;
      if (obs_s !== exp_v) begin
        miscompares++; $display("FAIL full c%0d: got %h expected %h", c, obs_s, exp_v);
      end
      vectors++;
      if (c == 4 && {stall_o, count_o} !== {1'b1, 3'd4}) begin
        miscompares++; $display("FAIL full_stall: got stall %b count %0d expected 1/4", stall_o, count_o);
      end else if (c == 5 && {stall_o, issue_valid_o, issue_rob_tag_o} !== {1'b1, 1'b1, 4'd1}) begin
        miscompares++; $display("FAIL full_wake_oldest: got stall %b v %b tag %0d expected 1/1/1", stall_o, issue_valid_o, issue_rob_tag_o);
      end else if (c == 6 && {stall_o, count_o} !== {1'b0, 3'd3}) begin
        miscompares++; $display("FAIL full_release: got stall %b count %0d expected 0/3", stall_o, count_o);
      end
      tick();
    end
  endtask

  task automatic test_hold_reset();
    for (int c = 0; c < 4; c++) begin
      drive(c == 0, 4'd4, 0, 0, 65'h44, 65'h45, 0, 0, 0, 0);
      #1; exp_v = exp_bundle(); vectors++;
      if (obs_s !== exp_v) begin
        miscompares++; $display("FAIL hold c%0d: got %h expected %h", c, obs_s, exp_v);
      end
      vectors++;
      if (c > 0 && {issue_valid_o, issue_rob_tag_o, issue_val1_o} !== {1'b1, 4'd4, 65'h44}) begin
        miscompares++; $display("FAIL hold_stable c%0d: got v %b tag %0d val1 %h expected 1/4/44", c, issue_valid_o, issue_rob_tag_o, issue_val1_o);
      end
      tick();
    end
    #2;
    reset_i = 1'b0;
    #1;
    vectors++;
    if ({issue_valid_o, count_o, stall_o} !== 5'd0) begin
      miscompares++; $display("FAIL async_reset: got v %b count %0d stall %b expected 0/0/0", issue_valid_o, count_o, stall_o);
    end
    mq.delete();
    @(negedge clk_i);
    reset_i = 1'b1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 99) < 60, TW'($urandom_range(1, 8)),
            ($urandom_range(0, 1) != 0) ? TW'($urandom_range(1, 4)) : 4'd0,
            ($urandom_range(0, 2) == 0) ? TW'($urandom_range(1, 4)) : 4'd0,
            rnd65(), rnd65(), $urandom_range(0, 99) < 50, TW'($urandom_range(0, 4)),
            rnd65(), $urandom_range(0, 99) < 65);
      #1; exp_v = exp_bundle(); vectors++;
      if (obs_s !== exp_v) begin
        miscompares++; $display("FAIL random c%0d: got %h expected %h", c, obs_s, exp_v);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_ready_dispatch();
    test_wakeup(1'b0);
    test_wakeup(1'b1);
    test_age_order();
    test_full();
    test_hold_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Consumer end of the decode-to-reservation-station dispatch interface: one instance per functional-unit class (four in the core).
- Accepts dispatched operations with operand values and ROB tags.
- Snoops the completion broadcast to capture outstanding operands.
- Issues the oldest fully-ready operation to its functional unit over a valid/ready handshake, and back-pressures decode with a full indication.

Parameters:
- DEPTH, 4, number of entries.
- ROBsize, 8, ROB entries.
- ROBsizeLog, $clog2(ROBsize+1), tag width; tag 0 means "value present, nothing to wait for".

Ports:
- clk_i  in  1  clock, rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- write_en_i  in  1  dispatch request from decode.
- rob_tag_i  in  ROBsizeLog  destination ROB tag of the dispatched op.
- tag1_i, tag2_i  in  ROBsizeLog  operand producer tags; 0 means the value is already valid.
- val1_i, val2_i  in  65  operand values; bit 64 is carried unchanged.
- commands_i  in  10  control bundle, stored opaque.
- stall_o  out  1  all entries occupied.
- cdb_valid_i  in  1  completion broadcast valid.
- cdb_tag_i  in  ROBsizeLog  completing ROB tag.
- cdb_val_i  in  65  completing value.
- issue_valid_o  out  1  an op is presented to the functional unit.
- issue_ready_i  in  1  functional unit accepts.
- issue_rob_tag_o  out  ROBsizeLog  tag of the presented op.
- issue_val1_o, issue_val2_o  out  65  operand values.
- issue_commands_o  out  10  control bundle.
- count_o  out  $clog2(DEPTH+1)  occupied entries (debug and verification).

Behaviour:
- Storage:
  - Compacted age-ordered queue of DEPTH slots; slot 0 is the oldest.
  - Each slot holds: valid, rob_tag, tag1, val1, tag2, val2, commands.
- Reset (asynchronous assert, synchronous-safe deassert):
  - All valid bits 0, count_o 0, stall_o 0, issue_valid_o 0.
  - All issue data outputs 0.
- stall_o is combinational: (count == DEPTH). It does not look ahead to an issue in the same cycle, so a full station refuses the write even if it is issuing that cycle.
- Write is accepted when write_en_i & ~stall_o:
  - The entry goes into slot (count − issued_this_cycle), after the compaction shift.
  - Write while stalled is ignored; no state changes.
- Capture on write: for each operand, if its tag_i != 0 and cdb_valid_i and cdb_tag_i == tag_i, store cdb_val_i and tag 0 instead of the incoming val_i and tag.
- Snoop, every cycle, every valid slot: if slot tagN != 0 and cdb_valid_i and cdb_tag_i == tagN, then valN <= cdb_val_i and tagN <= 0 at the clock edge. A cdb_tag_i of 0 never matches.
- Ready: slot valid, tag1 == 0 and tag2 == 0, evaluated on registered state. An operand woken this cycle makes the entry eligible next cycle (1-cycle wakeup latency).
- Select:
  - Lowest-index (oldest) ready slot.
  - issue_* outputs are combinational from that slot.
  - issue_valid_o = any ready slot.
  - When issue_valid_o = 0, data outputs are driven 0.
- Handshake:
  - issue_valid_o & issue_ready_i at the edge removes the selected slot; younger slots shift down by one and keep their snoop updates.
  - With issue_ready_i low, the same (oldest ready) entry stays presented unless an older entry becomes ready, in which case the older one is presented.
- Latency: the earliest issue is the cycle after a write with ready operands.
- Simultaneous write and issue:
  - Count unchanged.
  - The new entry lands in slot count−1.
  - The new entry is not eligible for issue in its write cycle.
- Simultaneous snoop and shift: a shifted slot carries its updated (captured) value to its new position.
- Reset mid-operation clears all entries immediately; in-flight captures are lost.

Test Plan:
- Reset then idle: reset_i=0 for 2 cycles, release → count_o=0, stall_o=0, issue_valid_o=0, all issue data 0.
- Ready dispatch: write rob_tag=3, tag1=0, tag2=0, val1=5, val2=7 → next cycle issue_valid_o=1, tag=3, val1=5, val2=7; with issue_ready_i=1, count_o returns to 0 the following cycle.
- Wakeup: write rob_tag=2, tag1=5, tag2=0. Two cycles later, cdb_valid=1, cdb_tag=5, cdb_val=0x1234 → issue_valid_o rises the cycle after the broadcast with val1=0x1234. Repeat with the broadcast in the write cycle → same result, via capture on write.
- Age order: write A (tag1=6 pending), then B (ready), then C (ready) → B issues first. Broadcast tag 6 → A is presented ahead of C.
- Full and back-pressure: 4 writes with pending tags → stall_o=1, count_o=4; a fifth write_en_i is ignored. Wake the oldest and issue → stall_o drops the cycle after acceptance; the fifth write then lands in slot 3.
- Hold and reset: entry presented with issue_ready_i=0 for 3 cycles → outputs stable. Assert reset_i=0 mid-hold → issue_valid_o=0 and count_o=0 immediately, without waiting for a clock edge.
